fare_collector: RTL and testbench

- Upstream stage of the turnstile lock FSM.
- Accumulates coin credit. When credit reaches the fare, it issues a single-cycle coin pulse to the turnstile's coin input.
- Tracks the passage cycle through the turnstile's locked indication before it grants the next fare.
- Handles refunds, overflow rejection and an unlock-timeout fault.

---
 rtl/fare_collector.sv | 108 ++++++++++
 tb/tb_fare_collector.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fare_collector.sv
// Coin credit accumulator feeding the turnstile lock FSM: grants one coin pulse per
// fare, then follows the turnstile through unlock/lock before granting again.
module fare_collector #(
    parameter int FARE           = 4,
    parameter int VALUE_W        = 4,
    parameter int CREDIT_W       = 8,
    parameter int UNLOCK_TIMEOUT = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_coin_valid,
    input  logic [VALUE_W-1:0]  i_coin_value,
    input  logic                i_cancel,
    input  logic                i_locked,
    output logic                o_coin,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_refund,
    output logic [CREDIT_W-1:0] o_refund_amount,
    output logic                o_coin_reject,
    output logic                o_busy,
    output logic                o_timeout
);
    typedef enum logic [1:0] {IDLE, GRANT, WAIT_UNLOCK, WAIT_LOCK} state_t;

    localparam int CNT_W = $clog2(UNLOCK_TIMEOUT + 1);
    localparam logic [CREDIT_W:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0]   FARE_X     = (CREDIT_W + 1)'(FARE);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(UNLOCK_TIMEOUT - 1);

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit, credit_n, credit_in, amt_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [CREDIT_W:0]   sum, restored;
    logic                coin_ok, refund_n, reject_n, timeout_n;

    // Coin acceptance is one wide add; the carry-out bit is the overflow detector.
    assign sum       = {1'b0, credit} + {{(CREDIT_W + 1 - VALUE_W){1'b0}}, i_coin_value};
    assign coin_ok   = i_coin_valid && (sum <= CREDIT_MAX);
    assign credit_in = coin_ok ? sum[CREDIT_W-1:0] : credit;
    assign restored  = {1'b0, credit_in} + FARE_X;
    assign reject_n  = i_coin_valid && !coin_ok;

    always_comb begin
        state_n   = state;
        credit_n  = credit_in;
        cnt_n     = cnt;
        refund_n  = 1'b0;
        amt_n     = '0;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (i_cancel) begin
                    refund_n = (credit_in != '0);
                    amt_n    = credit_in;
                    credit_n = '0;
                end else if (({1'b0, credit} >= FARE_X) && i_locked) begin
                    state_n = GRANT;
                end
            end
            GRANT: begin
                credit_n = credit_in - FARE_X[CREDIT_W-1:0];
                cnt_n    = '0;
                state_n  = WAIT_UNLOCK;
            end
            WAIT_UNLOCK: begin
                if (!i_locked) begin
                    state_n = WAIT_LOCK;
                end else if (cnt == CNT_LAST) begin
                    // Turnstile never opened: give the fare back, saturating.
                    credit_n  = (restored > CREDIT_MAX) ? CREDIT_MAX[CREDIT_W-1:0]
                                                        : restored[CREDIT_W-1:0];
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (i_locked) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state           <= IDLE;
            credit          <= '0;
            cnt             <= '0;
            o_refund        <= 1'b0;
            o_refund_amount <= '0;
            o_coin_reject   <= 1'b0;
            o_timeout       <= 1'b0;
        end else begin
            state           <= state_n;
            credit          <= credit_n;
            cnt             <= cnt_n;
            o_refund        <= refund_n;
            o_refund_amount <= refund_n ? amt_n : '0;
            o_coin_reject   <= reject_n;
            o_timeout       <= timeout_n;
        end
    end

    assign o_coin   = (state == GRANT);
    assign o_busy   = (state != IDLE);
    assign o_credit = credit;
endmodule

// File: tb/tb_fare_collector.sv
// Directed bench: stimulus queues expected strobe events, a negedge monitor matches them.
module tb_fare_collector;
    logic       i_clk = 1'b0;
    logic       i_reset, i_coin_valid, i_cancel, i_locked;
    logic [3:0] i_coin_value;
    logic       o_coin, o_refund, o_coin_reject, o_busy, o_timeout;
    logic [7:0] o_credit, o_refund_amount;

    localparam logic [1:0] K_COIN = 2'd0, K_REFUND = 2'd1, K_REJECT = 2'd2, K_TIMEOUT = 2'd3;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] amt;
        logic [7:0] credit;
        logic       busy;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    fare_collector #(.FARE(4), .VALUE_W(4), .CREDIT_W(8), .UNLOCK_TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_coin_valid(i_coin_valid),
        .i_coin_value(i_coin_value), .i_cancel(i_cancel), .i_locked(i_locked),
        .o_coin(o_coin), .o_credit(o_credit), .o_refund(o_refund),
        .o_refund_amount(o_refund_amount), .o_coin_reject(o_coin_reject),
        .o_busy(o_busy), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [7:0] amt, input logic [7:0] cr,
                        input logic busy);
        ev_t e;
        e.kind = k; e.amt = amt; e.credit = cr; e.busy = busy;
        exp_q.push_back(e);
    endtask

    // Monitor side: consume one expected event for each strobe the DUT raises.
    task automatic take(input logic [1:0] k, input string name);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected strobe, credit=%0d", name, o_credit);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind !== k || e.credit !== o_credit || e.busy !== o_busy ||
            (k == K_REFUND && e.amt !== o_refund_amount)) begin
            n_fail++;
            $display("FAIL %s: got kind=%0d credit=%0d busy=%0d amt=%0d expected kind=%0d credit=%0d busy=%0d amt=%0d",
                     name, k, o_credit, o_busy, o_refund_amount, e.kind, e.credit, e.busy, e.amt);
        end
    endtask

    always @(negedge i_clk) begin
        if (!o_refund && o_refund_amount !== 8'd0) begin
            n_checks++;
            n_fail++;
            $display("FAIL refund_amount_idle: got %0d expected 0", o_refund_amount);
        end
        if (o_coin)        take(K_COIN, "coin_pulse");
        if (o_refund)      take(K_REFUND, "refund");
        if (o_coin_reject) take(K_REJECT, "coin_reject");
        if (o_timeout)     take(K_TIMEOUT, "timeout");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic coin(input logic [3:0] v);
        i_coin_valid = 1'b1; i_coin_value = v;
        tick();
        i_coin_valid = 1'b0; i_coin_value = 4'd0;
    endtask

    initial begin
        i_reset = 1'b1; i_coin_valid = 1'b0; i_coin_value = 4'd0;
        i_cancel = 1'b0; i_locked = 1'b1;
        tick(); tick();
        check("reset_credit", o_credit, 0);
        check("reset_busy", o_busy, 0);
        check("reset_strobes", {o_coin, o_refund, o_coin_reject, o_timeout}, 0);
        i_reset = 1'b0;
        tick();

        // Exact fare: 2 + 2, grant two edges after the second coin
        coin(4'd2);
        check("fare_credit_2", o_credit, 2);
        tick();
        coin(4'd2);
        check("fare_credit_4", o_credit, 4);
        check("fare_no_early_coin", o_coin, 0);
        push(K_COIN, 8'd0, 8'd4, 1'b1);
        tick();
        tick();
        check("fare_credit_after", o_credit, 0);
        check("fare_busy", o_busy, 1);

        // Full passage
        tick();
        i_locked = 1'b0;
        tick(); tick(); tick();
        check("passage_busy_lock", o_busy, 1);
        i_locked = 1'b1;
        tick();
        check("passage_idle", o_busy, 0);
        tick(); tick();
        check("passage_no_regrant", o_credit, 0);

        // Refund with a coin in the cancel cycle
        coin(4'd3);
        check("refund_credit_3", o_credit, 3);
        push(K_REFUND, 8'd4, 8'd0, 1'b0);
        i_cancel = 1'b1;
        coin(4'd1);
        i_cancel = 1'b0;
        tick();
        check("refund_cleared", {o_refund, o_refund_amount}, 0);
        i_cancel = 1'b1;
        tick();
        i_cancel = 1'b0;
        tick();
        check("cancel_zero_credit", o_credit, 0);

        // Overflow: build 250 with the turnstile open so no grant fires
        i_locked = 1'b0;
        for (int i = 0; i < 16; i++) coin(4'd15);
        coin(4'd10);
        check("ovf_credit_250", o_credit, 250);
        push(K_REJECT, 8'd0, 8'd250, 1'b0);
        coin(4'd9);
        check("ovf_credit_kept", o_credit, 250);
        coin(4'd5);
        check("ovf_credit_255", o_credit, 255);
        check("ovf_reject_once", o_coin_reject, 0);
        push(K_REFUND, 8'd255, 8'd0, 1'b0);
        i_cancel = 1'b1;
        tick();
        i_cancel = 1'b0;
        tick();

        // Unlock timeout with re-grant
        i_locked = 1'b1;
        coin(4'd6);
        push(K_COIN, 8'd0, 8'd6, 1'b1);
        tick();
        tick();
        check("to_credit_after_grant", o_credit, 2);
        for (int i = 0; i < 15; i++) tick();
        check("to_still_waiting", {o_busy, o_timeout}, 2'b10);
        push(K_TIMEOUT, 8'd0, 8'd6, 1'b0);
        tick();
        check("to_credit_restored", o_credit, 6);
        push(K_COIN, 8'd0, 8'd6, 1'b1);
        tick();
        tick();
        i_locked = 1'b0;
        tick();
        i_locked = 1'b1;
        tick();
        check("to_passage_done", {o_busy, o_credit}, {1'b0, 8'd2});

        // Reset in WAIT_LOCK with credit 3
        coin(4'd5);
        push(K_COIN, 8'd0, 8'd7, 1'b1);
        tick();
        tick();
        i_locked = 1'b0;
        tick();
        check("rst_pre_credit", o_credit, 3);
        check("rst_pre_busy", o_busy, 1);
        i_reset = 1'b1;
        tick();
        check("rst_credit", o_credit, 0);
        check("rst_busy", o_busy, 0);
        check("rst_strobes", {o_coin, o_refund, o_coin_reject, o_timeout, o_refund_amount}, 0);
        i_reset = 1'b0;
        i_locked = 1'b1;
        tick(); tick();

        check("events_all_seen", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
